// File: rtl/sv_upsampler_pkg.sv
// Shared definitions for the 2x interpolator: stream width and FSM state encoding.
package sv_upsampler_pkg;

    // Default sample width; matches the state-variable filter's stream width.
    localparam int SAMPLE_WIDTH = 16;

    // Pair-emission sequence: init -> wait for input -> midpoint -> current sample.
    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_WAIT = 2'd1,
        S_MID  = 2'd2,
        S_CUR  = 2'd3
    } state_e;

endpackage

// File: rtl/sv_upsampler.sv
// 2x interpolator: each accepted input sample produces a midpoint sample
// (tuser=1) followed by the sample itself (tuser=0) on the master stream.
module sv_upsampler
    import sv_upsampler_pkg::*;
#(
    parameter int WIDTH  = SAMPLE_WIDTH,
    parameter bit LINEAR = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tvalid_slave,
    output logic             tready_slave,
    input  logic [WIDTH-1:0] tdata_slave,
    output logic             tvalid_master,
    input  logic             tready_master,
    output logic [WIDTH-1:0] tdata_master,
    output logic             tuser_master
);

    state_e             state_q,         state_d;
    logic               tready_slave_q,  tready_slave_d;
    logic               tvalid_master_q, tvalid_master_d;
    logic [WIDTH-1:0]   tdata_master_q,  tdata_master_d;
    logic               tuser_master_q,  tuser_master_d;
    // Last accepted sample. It is the "previous" operand when the next input
    // arrives and the value emitted second in the current pair.
    logic [WIDTH-1:0]   cur_sample_q,    cur_sample_d;

    logic               in_xfer_s;
    logic               out_xfer_s;
    logic signed [WIDTH:0] sum_s;
    logic [WIDTH-1:0]   mid_s;

    // Handshakes and the midpoint: sign-extended sum, arithmetic shift (floor), truncate.
    always_comb begin
        in_xfer_s  = tvalid_slave & tready_slave_q;
        out_xfer_s = tvalid_master_q & tready_master;
        sum_s      = $signed({cur_sample_q[WIDTH-1], cur_sample_q})
                   + $signed({tdata_slave[WIDTH-1], tdata_slave});
        if (LINEAR) begin
            mid_s = WIDTH'(sum_s >>> 1);
        end else begin
            mid_s = tdata_slave;
        end
    end

    // Next-state and next-output computation for the pair sequencer.
    always_comb begin
        state_d         = state_q;
        tready_slave_d  = tready_slave_q;
        tvalid_master_d = tvalid_master_q;
        tdata_master_d  = tdata_master_q;
        tuser_master_d  = tuser_master_q;
        cur_sample_d    = cur_sample_q;
        case (state_q)
            S_INIT: begin
                tready_slave_d = 1'b1;
                state_d        = S_WAIT;
            end
            S_WAIT: begin
                tvalid_master_d = 1'b0;
                if (in_xfer_s) begin
                    cur_sample_d    = tdata_slave;
                    tdata_master_d  = mid_s;
                    tuser_master_d  = 1'b1;
                    tvalid_master_d = 1'b1;
                    tready_slave_d  = 1'b0;
                    state_d         = S_MID;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_MID: begin
                if (out_xfer_s) begin
                    tdata_master_d = cur_sample_q;
                    tuser_master_d = 1'b0;
                    state_d        = S_CUR;
                end else begin
                    state_d = S_MID;
                end
            end
            S_CUR: begin
                if (out_xfer_s) begin
                    tvalid_master_d = 1'b0;
                    tuser_master_d  = 1'b0;
                    tready_slave_d  = 1'b1;
                    state_d         = S_WAIT;
                end else begin
                    state_d = S_CUR;
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers; reset discards any pending pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_INIT;
            tready_slave_q  <= 1'b0;
            tvalid_master_q <= 1'b0;
            tdata_master_q  <= {WIDTH{1'b0}};
            tuser_master_q  <= 1'b0;
            cur_sample_q    <= {WIDTH{1'b0}};
        end else begin
            state_q         <= state_d;
            tready_slave_q  <= tready_slave_d;
            tvalid_master_q <= tvalid_master_d;
            tdata_master_q  <= tdata_master_d;
            tuser_master_q  <= tuser_master_d;
            cur_sample_q    <= cur_sample_d;
        end
    end

    assign tready_slave  = tready_slave_q;
    assign tvalid_master = tvalid_master_q;
    assign tdata_master  = tdata_master_q;
    assign tuser_master  = tuser_master_q;

endmodule

// File: tb/tb_sv_upsampler.sv
// Scoreboard bench for sv_upsampler: one LINEAR=1 and one LINEAR=0 instance
// share the input stimulus and the downstream ready.
module tb_sv_upsampler;

    localparam int W = 16;

    typedef struct {
        int d;
        bit u;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         tvalid_slave;
    logic [W-1:0] tdata_slave;
    logic         tready_master;
    logic         rdy1, vld1, usr1;
    logic [W-1:0] dat1;
    logic         rdy0, vld0, usr0;
    logic [W-1:0] dat0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_out1   = 0;
    int n_out0   = 0;
    bit stop_rand;

    exp_t q1[$];
    exp_t q0[$];
    int   obs1[$];
    int   obs0[$];
    int   m_prev1 = 0;
    int   m_prev0 = 0;

    always #5 clk = ~clk;

    sv_upsampler #(.WIDTH(W), .LINEAR(1'b1)) dut_lin (
        .clk(clk), .reset(reset),
        .tvalid_slave(tvalid_slave), .tready_slave(rdy1), .tdata_slave(tdata_slave),
        .tvalid_master(vld1), .tready_master(tready_master),
        .tdata_master(dat1), .tuser_master(usr1)
    );

    sv_upsampler #(.WIDTH(W), .LINEAR(1'b0)) dut_zoh (
        .clk(clk), .reset(reset),
        .tvalid_slave(tvalid_slave), .tready_slave(rdy0), .tdata_slave(tdata_slave),
        .tvalid_master(vld0), .tready_master(tready_master),
        .tdata_master(dat0), .tuser_master(usr0)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    // Floor of s/2 using plain integer arithmetic (division truncates toward zero).
    function automatic int floor_half(input int s);
        if (s < 0 && (s % 2) != 0) return (s - 1) / 2;
        return s / 2;
    endfunction

    function automatic int sval(input logic [W-1:0] v);
        return int'($signed(v));
    endfunction

    // Reference model: on each input transfer, queue the expected output pair.
    always @(negedge clk) begin
        if (reset) begin
            q1.delete();
            q0.delete();
            m_prev1 = 0;
            m_prev0 = 0;
        end else begin
            if (tvalid_slave && rdy1) begin
                q1.push_back('{floor_half(m_prev1 + sval(tdata_slave)), 1'b1});
                q1.push_back('{sval(tdata_slave), 1'b0});
                m_prev1 = sval(tdata_slave);
            end
            if (tvalid_slave && rdy0) begin
                q0.push_back('{sval(tdata_slave), 1'b1});
                q0.push_back('{sval(tdata_slave), 1'b0});
                m_prev0 = sval(tdata_slave);
            end
        end
    end

    // Monitor: on each output transfer, pop and compare.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (vld1 && tready_master) begin
                if (q1.size() == 0) begin
                    fail_now("lin_unexpected_output");
                end else begin
                    e = q1.pop_front();
                    chk("lin_data", sval(dat1), e.d);
                    chk("lin_user", int'(usr1), int'(e.u));
                end
                obs1.push_back(sval(dat1));
                n_out1++;
            end
            if (vld0 && tready_master) begin
                if (q0.size() == 0) begin
                    fail_now("zoh_unexpected_output");
                end else begin
                    e = q0.pop_front();
                    chk("zoh_data", sval(dat0), e.d);
                    chk("zoh_user", int'(usr0), int'(e.u));
                end
                obs0.push_back(sval(dat0));
                n_out0++;
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        tvalid_slave = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_tready_slave", int'(rdy1), 0);
        chk("rst_tvalid_master", int'(vld1), 0);
        chk("rst_tdata_master", sval(dat1), 0);
        chk("rst_tuser_master", int'(usr1), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rdy_before_init_edge", int'(rdy1), 0);
        @(posedge clk);
        #1;
        chk("rdy_after_init_edge", int'(rdy1), 1);
    endtask

    // Present one sample and wait for its transfer; called just after a rising edge.
    task automatic send(input int x, input bit hold);
        int k = 0;
        tvalid_slave = 1'b1;
        tdata_slave  = x[W-1:0];
        while (!rdy1 && k < 200) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (!rdy1) begin
            fail_now("send_timeout");
        end else begin
            @(posedge clk);
            #1;
        end
        if (!hold) tvalid_slave = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while ((q1.size() != 0 || q0.size() != 0) && k < 500) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (q1.size() != 0 || q0.size() != 0) fail_now("drain_timeout");
    endtask

    task automatic check_obs(input string nm, input bit lin,
                             input int e0, input int e1, input int e2, input int e3);
        int exp_v[4];
        int got[$];
        exp_v = '{e0, e1, e2, e3};
        got = lin ? obs1 : obs0;
        chk({nm, "_count"}, got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("%s_%0d", nm, i), got[i], exp_v[i]);
        end
    endtask

    initial begin
        int base1;
        int base0;
        reset         = 1'b1;
        tvalid_slave  = 1'b0;
        tdata_slave   = {W{1'b0}};
        tready_master = 1'b1;
        stop_rand     = 1'b0;

        // 1: basic pair generation
        do_reset();
        obs1.delete(); obs0.delete();
        send(1000, 1'b0);
        send(2000, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_obs("t1_lin", 1'b1, 500, 1000, 1500, 2000);
        check_obs("t1_zoh", 1'b0, 1000, 1000, 2000, 2000);

        // 2: floor rounding on negative sums
        do_reset();
        obs1.delete(); obs0.delete();
        send(-3, 1'b0);
        send(0, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_obs("t2_lin", 1'b1, -2, -3, -2, 0);
        check_obs("t2_zoh", 1'b0, -3, -3, 0, 0);

        // 3: extremes without wrap
        do_reset();
        obs1.delete(); obs0.delete();
        send(32767, 1'b0);
        send(-32768, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check_obs("t3_lin", 1'b1, 16383, 32767, -1, -32768);
        obs1.delete();
        send(32767, 1'b0);
        send(32767, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t3_max_avg", obs1.size() > 2 ? obs1[2] : 0, 32767);

        // 4: downstream stall in the midpoint state
        do_reset();
        obs1.delete(); obs0.delete();
        tready_master = 1'b0;
        send(1000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_data", sval(dat1), 500);
            chk("stall_valid", int'(vld1), 1);
            chk("stall_user", int'(usr1), 1);
            chk("stall_rdy_slave", int'(rdy1), 0);
        end
        @(posedge clk);
        #1;
        tready_master = 1'b1;
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t4_count", obs1.size(), 2);
        chk("t4_second", obs1.size() > 1 ? obs1[1] : 0, 1000);

        // 5: continuous valid, random samples, random downstream ready
        base1 = n_out1;
        base0 = n_out0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    int x;
                    x = int'($urandom_range(0, 65535)) - 32768;
                    if (i == 10) x = 32767;
                    if (i == 11) x = -32768;
                    send(x, 1'b1);
                end
                stop_rand = 1'b1;
            end
            begin
                while (!stop_rand) begin
                    tready_master = 1'($urandom_range(0, 1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        tvalid_slave  = 1'b0;
        tready_master = 1'b1;
        drain();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_lin_outputs", n_out1 - base1, 200);
        chk("t5_zoh_outputs", n_out0 - base0, 200);

        // 6: reset while the current sample is pending
        do_reset();
        tready_master = 1'b0;
        send(1000, 1'b0);
        tready_master = 1'b1;
        @(posedge clk);
        #1;
        tready_master = 1'b0;
        chk("t6_in_cur_valid", int'(vld1), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", int'(vld1), 0);
        chk("t6_rst_data", sval(dat1), 0);
        tready_master = 1'b1;
        do_reset();
        obs1.delete(); obs0.delete();
        send(400, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        chk("t6_count", obs1.size(), 2);
        chk("t6_mid", obs1.size() > 0 ? obs1[0] : 0, 200);
        chk("t6_cur", obs1.size() > 1 ? obs1[1] : 0, 400);

        // Idle in the wait state with no input
        repeat (10) @(posedge clk);
        #1;
        chk("idle_rdy_slave", int'(rdy1), 1);
        chk("idle_valid", int'(vld1), 0);
        chk("final_lin_queue_empty", q1.size(), 0);
        chk("final_zoh_queue_empty", q0.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule
